// File: rtl/cmd_response_deserializer.sv
// SD-card CMD-line response receiver: waits for a start bit, shifts in a 48/136-bit frame, checks framing and CRC7.
// Optional CRC7 checking is built only when CMD_RESP_CRC_CHECK_EN is defined; otherwise crc_err is tied low.
module cmd_response_deserializer #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int BITS_COUNTER   = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         long_resp,
   input  logic         cmd_in,
   output logic [135:0] resp,
   output logic         busy,
   output logic         done,
   output logic         timeout,
   output logic         frame_err,
   output logic         crc_err
);

   typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE} state_t;

   localparam logic [BITS_COUNTER-1:0] CNT_ONE    = BITS_COUNTER'(1);
   localparam logic [BITS_COUNTER-1:0] SHORT_LAST = BITS_COUNTER'(47);
   localparam logic [BITS_COUNTER-1:0] LONG_LAST  = BITS_COUNTER'(135);
   localparam logic [BITS_COUNTER-1:0] WAIT_LAST  = BITS_COUNTER'(TIMEOUT_CYCLES - 1);

   state_t                  state;
   logic                    long_q;
   logic [BITS_COUNTER-1:0] bit_cnt;
   logic [BITS_COUNTER-1:0] wait_cnt;
   logic [134:0]            shift;
   logic [135:0]            shift_next;
   logic                    last_bit;
   logic                    frame_bad;

   // bit_cnt holds the number of bits already captured, so last_bit marks the edge sampling the end bit
   always_comb begin
      shift_next = {shift, cmd_in};
      last_bit   = (bit_cnt == (long_q ? LONG_LAST : SHORT_LAST));
      frame_bad  = !cmd_in || (long_q ? shift_next[134] : shift_next[46]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         long_q    <= 1'b0;
         bit_cnt   <= '0;
         wait_cnt  <= '0;
         shift     <= '0;
         resp      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         timeout   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         done      <= 1'b0;
         timeout   <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= WAIT_START;
                  long_q   <= long_resp;
                  wait_cnt <= '0;
                  bit_cnt  <= '0;
                  shift    <= '0;
                  busy     <= 1'b1;
               end
            end
            WAIT_START: begin
               if (!cmd_in) begin
                  shift   <= shift_next[134:0];
                  bit_cnt <= CNT_ONE;
                  state   <= RECEIVE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_ONE;
                  if (wait_cnt == WAIT_LAST) begin
                     timeout <= 1'b1;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end
               end
            end
            RECEIVE: begin
               shift   <= shift_next[134:0];
               bit_cnt <= bit_cnt + CNT_ONE;
               if (last_bit) begin
                  resp      <= shift_next;
                  frame_err <= frame_bad;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CMD_RESP_CRC_CHECK_EN
   localparam logic [BITS_COUNTER-1:0] CRC_SHORT_LAST = BITS_COUNTER'(39);
   localparam logic [BITS_COUNTER-1:0] CRC_LONG_FIRST = BITS_COUNTER'(8);
   localparam logic [BITS_COUNTER-1:0] CRC_LONG_LAST  = BITS_COUNTER'(127);

   logic [6:0] crc;
   logic [6:0] crc_next;
   logic       crc_take;

   // Short frames cover bits 1-40; the start bit is 0 so skipping it leaves the zero seed untouched
   always_comb begin
      crc_take = long_q ? (bit_cnt >= CRC_LONG_FIRST && bit_cnt <= CRC_LONG_LAST)
                        : (bit_cnt <= CRC_SHORT_LAST);
      crc_next = {crc[5:0], 1'b0} ^ ((crc[6] ^ cmd_in) ? 7'h09 : 7'h00);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         crc     <= '0;
         crc_err <= 1'b0;
      end else begin
         crc_err <= 1'b0;
         if (state == IDLE && start) begin
            crc <= '0;
         end else if (state == RECEIVE) begin
            if (crc_take) crc <= crc_next;
            if (last_bit) crc_err <= (crc != shift_next[7:1]);
         end
      end
   end
`else
   assign crc_err = 1'b0;
`endif

endmodule
